// File: rtl/pcx_fpga_pkg.sv
// Shared types and constants for the FPGA SPARC wrapper PCX receiver.
// A FIFO entry packs the atomic flag, one-hot destination and packet payload.
package pcx_fpga_pkg;

   localparam int PCX_DATA_W = 124;
   localparam int PCX_DEST_W = 5;

   localparam logic [PCX_DEST_W-1:0] DEST_L2B0 = 5'b00001;
   localparam logic [PCX_DEST_W-1:0] DEST_L2B1 = 5'b00010;
   localparam logic [PCX_DEST_W-1:0] DEST_L2B2 = 5'b00100;
   localparam logic [PCX_DEST_W-1:0] DEST_L2B3 = 5'b01000;
   localparam logic [PCX_DEST_W-1:0] DEST_IO   = 5'b10000;

   typedef struct packed {
      logic                  atom;
      logic [PCX_DEST_W-1:0] dest;
      logic [PCX_DATA_W-1:0] data;
   } pcx_entry_t;

   localparam int PCX_ENTRY_W = $bits(pcx_entry_t);

   function automatic logic is_onehot(input logic [PCX_DEST_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/pcx_fpga_fifo.sv
// Synchronous FIFO with occupancy count; full and empty are derived from the count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module pcx_fpga_fifo #(
   parameter int WIDTH = 130,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             gclk,
   input  logic             reset_l,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array has no reset; count alone decides which entries are live.
   always_ff @(posedge gclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge gclk or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pcx_fpga_rcv.sv
// PCX receiver: registers the PQ request, writes the PA packet into a FIFO,
// presents the head on valid/ready and returns one grant per packet consumed.
module pcx_fpga_rcv
   import pcx_fpga_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                  gclk,
   input  logic                  reset_l,
   input  logic [PCX_DEST_W-1:0] spc_pcx_req_pq,
   input  logic                  spc_pcx_atom_pq,
   input  logic [PCX_DATA_W-1:0] spc_pcx_data_pa,
   output logic [PCX_DEST_W-1:0] pcx_spc_grant_px,
   output logic                  pcx_pkt_vld,
   input  logic                  pcx_pkt_rdy,
   output logic [PCX_DATA_W-1:0] pcx_pkt_data,
   output logic [PCX_DEST_W-1:0] pcx_pkt_dest,
   output logic                  pcx_pkt_atom,
   output logic                  pcx_ovfl_err,
   output logic                  pcx_req_err
);

   logic                  pq_vld;
   logic                  pq_atom;
   logic [PCX_DEST_W-1:0] pq_dest;
   pcx_entry_t            wr_entry;
   pcx_entry_t            head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;

   assign wr_entry = '{atom: pq_atom, dest: pq_dest, data: spc_pcx_data_pa};

   pcx_fpga_fifo #(
      .WIDTH (PCX_ENTRY_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .gclk    (gclk),
      .reset_l (reset_l),
      .push    (pq_vld),
      .pop     (pop),
      .din     (wr_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .dout    (head)
   );

   assign pcx_pkt_vld = ~fifo_empty;
   assign pop         = pcx_pkt_vld & pcx_pkt_rdy;

   // Head fields read as zero when nothing is queued, hiding stale storage.
   assign pcx_pkt_data = pcx_pkt_vld ? head.data : '0;
   assign pcx_pkt_dest = pcx_pkt_vld ? head.dest : '0;
   assign pcx_pkt_atom = pcx_pkt_vld ? head.atom : 1'b0;

   always_ff @(posedge gclk or negedge reset_l) begin
      if (!reset_l) begin
         pq_vld           <= 1'b0;
         pq_atom          <= 1'b0;
         pq_dest          <= '0;
         pcx_spc_grant_px <= '0;
         pcx_ovfl_err     <= 1'b0;
         pcx_req_err      <= 1'b0;
      end else begin
         pq_vld  <= is_onehot(spc_pcx_req_pq);
         pq_atom <= spc_pcx_atom_pq;
         pq_dest <= spc_pcx_req_pq;
         if ((spc_pcx_req_pq != '0) && !is_onehot(spc_pcx_req_pq)) pcx_req_err <= 1'b1;
         // A full FIFO still takes the write when the head leaves in the same cycle.
         if (pq_vld && fifo_full && !pop) pcx_ovfl_err <= 1'b1;
         pcx_spc_grant_px <= pop ? head.dest : '0;
      end
   end

endmodule

// File: tb/tb_pcx_fpga_rcv.sv
// Directed bench for pcx_fpga_rcv: a scoreboard queue mirrors FIFO contents and
// a negedge monitor checks head fields, valid and grant timing every cycle.
module tb_pcx_fpga_rcv;
   import pcx_fpga_pkg::*;

   logic                  gclk = 1'b0;
   logic                  reset_l = 1'b0;
   logic [PCX_DEST_W-1:0] spc_pcx_req_pq = '0;
   logic                  spc_pcx_atom_pq = 1'b0;
   logic [PCX_DATA_W-1:0] spc_pcx_data_pa = '0;
   logic [PCX_DEST_W-1:0] pcx_spc_grant_px;
   logic                  pcx_pkt_vld;
   logic                  pcx_pkt_rdy = 1'b0;
   logic [PCX_DATA_W-1:0] pcx_pkt_data;
   logic [PCX_DEST_W-1:0] pcx_pkt_dest;
   logic                  pcx_pkt_atom;
   logic                  pcx_ovfl_err;
   logic                  pcx_req_err;

   always #5 gclk = ~gclk;

   pcx_fpga_rcv #(.DEPTH(16), .AW(4)) dut (
      .gclk             (gclk),
      .reset_l          (reset_l),
      .spc_pcx_req_pq   (spc_pcx_req_pq),
      .spc_pcx_atom_pq  (spc_pcx_atom_pq),
      .spc_pcx_data_pa  (spc_pcx_data_pa),
      .pcx_spc_grant_px (pcx_spc_grant_px),
      .pcx_pkt_vld      (pcx_pkt_vld),
      .pcx_pkt_rdy      (pcx_pkt_rdy),
      .pcx_pkt_data     (pcx_pkt_data),
      .pcx_pkt_dest     (pcx_pkt_dest),
      .pcx_pkt_atom     (pcx_pkt_atom),
      .pcx_ovfl_err     (pcx_ovfl_err),
      .pcx_req_err      (pcx_req_err)
   );

   int checks = 0;
   int errors = 0;
   pcx_entry_t            sb[$];
   logic                  prev_ok = 1'b0;
   logic                  prev_atom = 1'b0;
   logic [PCX_DEST_W-1:0] prev_dest = '0;
   logic                  drop_next = 1'b0;
   logic [PCX_DEST_W-1:0] exp_grant = '0;

   task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [PCX_DATA_W-1:0] mk(input int i);
      logic [31:0] s;
      s = 32'(i) * 32'h9E3779B1 + 32'h1234;
      return {s, ~s, s ^ 32'hA5A5A5A5, s[27:0]};
   endfunction

   function automatic logic [PCX_DEST_W-1:0] dest_of(input int i);
      logic [PCX_DEST_W-1:0] d;
      d = 5'b00001;
      return d << (i % 5);
   endfunction

   // One cycle: issue a new PQ request and the PA data of the previous one.
   task automatic beat(input logic [PCX_DEST_W-1:0] req, input logic atom,
                       input logic [PCX_DATA_W-1:0] data, input logic rdy);
      spc_pcx_req_pq  = req;
      spc_pcx_atom_pq = atom;
      spc_pcx_data_pa = data;
      pcx_pkt_rdy     = rdy;
      @(posedge gclk); #1;
      if (prev_ok && !drop_next) sb.push_back('{atom: prev_atom, dest: prev_dest, data: data});
      drop_next = 1'b0;
      prev_ok   = ((req != '0) && ((req & (req - 1'b1)) == '0));
      prev_dest = req;
      prev_atom = atom;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) beat('0, 1'b0, '0, 1'b1);
      chk("drain_budget", 32'(sb.size()), 32'd0);
      beat('0, 1'b0, '0, 1'b1);
      chk("drained_vld", pcx_pkt_vld, 1'b0);
   endtask

   always @(negedge gclk) begin
      if (!reset_l) begin
         exp_grant = '0;
      end else begin
         chk("grant", pcx_spc_grant_px, exp_grant);
         chk("vld", pcx_pkt_vld, sb.size() != 0);
         if (pcx_pkt_vld && sb.size() != 0)
            chk("head", {pcx_pkt_atom, pcx_pkt_dest, pcx_pkt_data}, sb[0]);
         else if (!pcx_pkt_vld)
            chk("idle_head", {pcx_pkt_atom, pcx_pkt_dest, pcx_pkt_data}, '0);
         if (pcx_pkt_vld && pcx_pkt_rdy && sb.size() != 0) begin
            exp_grant = sb[0].dest;
            void'(sb.pop_front());
         end else begin
            exp_grant = '0;
         end
      end
   end

   initial begin
      // Reset state
      #12;
      chk("rst_vld", pcx_pkt_vld, 1'b0);
      chk("rst_grant", pcx_spc_grant_px, 5'b0);
      chk("rst_ovfl", pcx_ovfl_err, 1'b0);
      chk("rst_reqerr", pcx_req_err, 1'b0);
      chk("rst_head", {pcx_pkt_atom, pcx_pkt_dest, pcx_pkt_data}, '0);
      @(posedge gclk); #1;
      reset_l = 1'b1;

      // Single request: vld at N+2, grant at N+3 for one cycle
      beat(DEST_L2B0, 1'b0, '0, 1'b1);
      beat('0, 1'b0, 124'hA5, 1'b1);
      chk("single_vld", pcx_pkt_vld, 1'b1);
      chk("single_data", pcx_pkt_data, 124'hA5);
      chk("single_dest", pcx_pkt_dest, DEST_L2B0);
      beat('0, 1'b0, '0, 1'b1);
      chk("single_grant", pcx_spc_grant_px, DEST_L2B0);
      beat('0, 1'b0, '0, 1'b1);
      chk("single_grant_off", pcx_spc_grant_px, 5'b0);

      // Atomic pair to the same destination
      beat(DEST_L2B2, 1'b1, '0, 1'b1);
      beat(DEST_L2B2, 1'b0, mk(100), 1'b1);
      chk("atom_first", pcx_pkt_atom, 1'b1);
      beat('0, 1'b0, mk(101), 1'b1);
      chk("atom_second", pcx_pkt_atom, 1'b0);
      chk("atom_grant0", pcx_spc_grant_px, DEST_L2B2);
      beat('0, 1'b0, '0, 1'b1);
      chk("atom_grant1", pcx_spc_grant_px, DEST_L2B2);
      drain();

      // Backpressure: two credits per destination held with rdy low
      for (int i = 0; i < 10; i++) beat(dest_of(i), 1'b0, mk(200 + i - 1), 1'b0);
      beat('0, 1'b0, mk(209), 1'b0);
      beat('0, 1'b0, '0, 1'b0);
      chk("bp_count", 32'(sb.size()), 32'd10);
      chk("bp_grant", pcx_spc_grant_px, 5'b0);
      chk("bp_ovfl", pcx_ovfl_err, 1'b0);
      drain();

      // Multi-hot request is dropped and flagged
      beat(5'b00011, 1'b0, '0, 1'b1);
      chk("mh_err", pcx_req_err, 1'b1);
      beat('0, 1'b0, mk(300), 1'b1);
      chk("mh_no_write", pcx_pkt_vld, 1'b0);
      beat('0, 1'b0, '0, 1'b1);
      chk("mh_no_grant", pcx_spc_grant_px, 5'b0);

      // Overflow: 16 fill the FIFO, the 17th is dropped, the 18th meets a pop
      for (int i = 0; i < 17; i++) beat(dest_of(i), 1'b0, mk(400 + i - 1), 1'b0);
      chk("ovfl_before", pcx_ovfl_err, 1'b0);
      drop_next = 1'b1;
      beat(DEST_IO, 1'b0, mk(416), 1'b0);
      chk("ovfl_set", pcx_ovfl_err, 1'b1);
      beat('0, 1'b0, mk(417), 1'b1);
      chk("full_pushpop_count", 32'(sb.size()), 32'd16);
      drain();
      chk("ovfl_sticky", pcx_ovfl_err, 1'b1);

      // Mid-operation reset with queued packets, a live grant and a pending PA beat
      for (int i = 0; i < 4; i++) beat(dest_of(i), 1'b0, mk(500 + i - 1), 1'b0);
      beat(DEST_L2B1, 1'b0, mk(503), 1'b1);
      chk("prerst_grant", pcx_spc_grant_px, DEST_L2B0);
      spc_pcx_req_pq = '0;
      pcx_pkt_rdy    = 1'b0;
      reset_l        = 1'b0;
      #1;
      chk("midrst_vld", pcx_pkt_vld, 1'b0);
      chk("midrst_grant", pcx_spc_grant_px, 5'b0);
      chk("midrst_errs", {pcx_ovfl_err, pcx_req_err}, 2'b00);
      sb.delete();
      prev_ok = 1'b0;
      @(posedge gclk); #1;
      reset_l = 1'b1;
      beat('0, 1'b0, mk(600), 1'b1);
      chk("postrst_vld", pcx_pkt_vld, 1'b0);
      beat('0, 1'b0, '0, 1'b1);
      chk("postrst_grant", pcx_spc_grant_px, 5'b0);
      beat('0, 1'b0, '0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
